// File: rtl/case_7_sdiv_13s_4s_13_seq_pkg.sv
// ----------------------------------------------------------------------------
// case_7_div_pkg
// Shared types and constants for the 13s / 4s iterative signed divider.
//   state_t     : divider FSM states (IDLE, CALC, FIX)
//   DIVIDEND_W  : dividend / quotient width (signed)
//   DIVISOR_W   : divisor width (signed)
//   CNT_W       : iteration counter width
//   abs_ext     : signed dividend -> unsigned magnitude, one bit wider
//   abs_ext_div : signed divisor  -> unsigned magnitude, one bit wider
// ----------------------------------------------------------------------------
package case_7_div_pkg;

    localparam int unsigned DIVIDEND_W = 13;
    localparam int unsigned DIVISOR_W  = 4;
    localparam int unsigned CNT_W      = $clog2(DIVIDEND_W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    // One extra bit so the most negative value (-4096) has a magnitude.
    function automatic logic [DIVIDEND_W:0] abs_ext(input logic [DIVIDEND_W-1:0] v);
        logic [DIVIDEND_W:0] x;
        x = {v[DIVIDEND_W-1], v};
        return v[DIVIDEND_W-1] ? -x : x;
    endfunction

    function automatic logic [DIVISOR_W:0] abs_ext_div(input logic [DIVISOR_W-1:0] v);
        logic [DIVISOR_W:0] x;
        x = {v[DIVISOR_W-1], v};
        return v[DIVISOR_W-1] ? -x : x;
    endfunction

endpackage

// File: rtl/case_7_sdiv_13s_4s_13_seq_if.sv
// ----------------------------------------------------------------------------
// case_7_sdiv_13s_4s_13_seq_if
// Start/done handshake bundle of the iterative signed divider.
//   ce    : clock enable (master -> slave)
//   start : division request, taken when ready=1 and ce=1
//   ready : divider idle, start accepted this cycle
//   din0  : signed dividend
//   din1  : signed divisor
//   done  : one-cycle result strobe (held while ce=0)
//   dout  : signed quotient, holds until the next done
//   rem   : signed remainder, only when SDIV_REM_OUT_EN is defined
// Optional feature macro: SDIV_REM_OUT_EN
// ----------------------------------------------------------------------------
interface case_7_sdiv_13s_4s_13_seq_if
    import case_7_div_pkg::*;
#(
    parameter int unsigned DIN0_W = DIVIDEND_W,
    parameter int unsigned DIN1_W = DIVISOR_W,
    parameter int unsigned DOUT_W = DIVIDEND_W
);

    logic              ce;
    logic              start;
    logic              ready;
    logic [DIN0_W-1:0] din0;
    logic [DIN1_W-1:0] din1;
    logic              done;
    logic [DOUT_W-1:0] dout;

`ifdef SDIV_REM_OUT_EN
    logic [DIN1_W-1:0] rem;

    modport master (output ce, start, din0, din1, input ready, done, dout, rem);
    modport slave  (input ce, start, din0, din1, output ready, done, dout, rem);
`else
    modport master (output ce, start, din0, din1, input ready, done, dout);
    modport slave  (input ce, start, din0, din1, output ready, done, dout);
`endif

endinterface

// File: rtl/case_7_sdiv_13s_4s_13_seq_step.sv
// ----------------------------------------------------------------------------
// case_7_sdiv_step
// One combinational radix-2 restoring division step on magnitudes.
//   i_prem : partial remainder (always < divisor magnitude)
//   i_bit  : next dividend bit shifted in
//   i_dmag : divisor magnitude, DIVISOR_W+1 bits
//   o_prem : next partial remainder
//   o_qbit : quotient bit produced by this step
// ----------------------------------------------------------------------------
module case_7_sdiv_step
    import case_7_div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] i_prem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W:0]   i_dmag,
    output logic [DIVISOR_W-1:0] o_prem,
    output logic                 o_qbit
);

    logic [DIVISOR_W:0] w_shift;
    logic [DIVISOR_W:0] w_trial;

    // Shifted value is at most 15 and the divisor at most 8, so the
    // trial difference always fits DIVISOR_W+1 signed bits.
    assign w_shift = {i_prem, i_bit};
    assign w_trial = w_shift - i_dmag;
    assign o_qbit  = ~w_trial[DIVISOR_W];
    assign o_prem  = o_qbit ? w_trial[DIVISOR_W-1:0] : w_shift[DIVISOR_W-1:0];

endmodule

// File: rtl/case_7_sdiv_13s_4s_13_seq.sv
// ----------------------------------------------------------------------------
// case_7_sdiv_13s_4s_13_seq
// Iterative signed divider, 13-bit dividend / 4-bit divisor -> 13-bit
// quotient, truncating toward zero. One division in flight; done follows the
// accepted start by 14 enabled cycles. ce=0 freezes everything.
//   ap_clk : clock, rising edge
//   ap_rst : synchronous active-high reset
//   bus    : slave side of case_7_sdiv_13s_4s_13_seq_if (ce, start, ready,
//            din0, din1, done, dout [, rem])
// Divide by zero returns -1 (rem 0); -4096 / -1 wraps to -4096.
// Optional feature macro: SDIV_REM_OUT_EN (adds signed remainder output rem,
// sign of the dividend).
// ----------------------------------------------------------------------------
module case_7_sdiv_13s_4s_13_seq
    import case_7_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 14,
    parameter int din0_WIDTH = 13,
    parameter int din1_WIDTH = 4,
    parameter int dout_WIDTH = 13
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    case_7_sdiv_13s_4s_13_seq_if.slave bus
);

    if (din0_WIDTH != int'(DIVIDEND_W) || din1_WIDTH != int'(DIVISOR_W) ||
        dout_WIDTH != din0_WIDTH || NUM_STAGE != din0_WIDTH + 1 || ID < 0) begin : g_bad_cfg
        $error("case_7_sdiv_13s_4s_13_seq: unsupported parameter set");
    end

    state_t                r_state;
    state_t                w_state_next;
    logic [DIVIDEND_W:0]   r_dvd;
    logic [DIVISOR_W:0]    r_dmag;
    logic [DIVIDEND_W-2:0] r_quo;
    logic [DIVISOR_W-1:0]  r_prem;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_sign_q;
    logic                  r_sign_z;
    logic [DIVIDEND_W-1:0] r_dout;

    logic                  w_ready;
    logic                  w_done;
    logic                  w_accept;
    logic                  w_step;
    logic                  w_last;
    logic                  w_bit;
    logic                  w_qbit;
    logic [DIVISOR_W-1:0]  w_prem_next;
    logic [DIVIDEND_W-1:0] w_quo_next;
    logic [DIVIDEND_W-1:0] w_quo_final;

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = ~ap_rst;
                if (bus.ce && bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                if (bus.ce) begin
                    w_step = 1'b1;
                    if (r_cnt == '0) begin
                        w_last       = 1'b1;
                        w_state_next = FIX;
                    end
                end
            end
            FIX: begin
                w_done = 1'b1;
                if (bus.ce) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_bit = r_dvd[r_cnt];

    case_7_sdiv_step u_step (
        .i_prem (r_prem),
        .i_bit  (w_bit),
        .i_dmag (r_dmag),
        .o_prem (w_prem_next),
        .o_qbit (w_qbit)
    );

    assign w_quo_next = {r_quo, w_qbit};

    // Sign fix-up is folded into the last CALC step so dout is already
    // registered and valid during the FIX (done) cycle.
    always_comb begin
        w_quo_final = w_quo_next;
        if (r_sign_z) begin
            w_quo_final = '1;
        end else if (r_sign_q) begin
            w_quo_final = -w_quo_next;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_dvd    <= '0;
            r_dmag   <= '0;
            r_quo    <= '0;
            r_prem   <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_z <= 1'b0;
            r_dout   <= '0;
        end else if (w_accept) begin
            r_dvd    <= abs_ext(bus.din0);
            r_dmag   <= abs_ext_div(bus.din1);
            r_quo    <= '0;
            r_prem   <= '0;
            r_cnt    <= CNT_W'(DIVIDEND_W - 1);
            r_sign_q <= bus.din0[DIVIDEND_W-1] ^ bus.din1[DIVISOR_W-1];
            r_sign_z <= (bus.din1 == '0);
        end else if (w_step) begin
            r_prem <= w_prem_next;
            r_quo  <= w_quo_next[DIVIDEND_W-2:0];
            if (w_last) begin
                r_dout <= w_quo_final;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.ready = w_ready;
    assign bus.done  = w_done;
    assign bus.dout  = r_dout;

`ifdef SDIV_REM_OUT_EN
    logic                 r_sign_a;
    logic [DIVISOR_W-1:0] r_rem;
    logic [DIVISOR_W-1:0] w_rem_final;

    always_comb begin
        w_rem_final = w_prem_next;
        if (r_sign_z) begin
            w_rem_final = '0;
        end else if (r_sign_a) begin
            w_rem_final = -w_prem_next;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_sign_a <= 1'b0;
            r_rem    <= '0;
        end else if (w_accept) begin
            r_sign_a <= bus.din0[DIVIDEND_W-1];
        end else if (w_last) begin
            r_rem <= w_rem_final;
        end
    end

    assign bus.rem = r_rem;
`endif

endmodule

// File: tb/tb_case_7_sdiv_13s_4s_13_seq.sv
// ----------------------------------------------------------------------------
// tb_case_7_sdiv_13s_4s_13_seq
// Bench for the 13s / 4s iterative signed divider. Expected quotient and
// remainder come from constants or from integer division in the bench;
// results are queued at start and compared when done is consumed.
// Remainder is compared when SDIV_REM_OUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_case_7_sdiv_13s_4s_13_seq;

    logic ap_clk;
    logic ap_rst;

    case_7_sdiv_13s_4s_13_seq_if #(.DIN0_W(13), .DIN1_W(4), .DOUT_W(13)) bus ();

    case_7_sdiv_13s_4s_13_seq #(
        .ID         (1),
        .NUM_STAGE  (14),
        .din0_WIDTH (13),
        .din1_WIDTH (4),
        .dout_WIDTH (13)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [12:0] q;
        logic [3:0]  r;
        int unsigned t_acc;
    } exp_t;

    typedef struct {
        logic signed [12:0] a;
        logic signed [3:0]  b;
        logic [12:0]        q;
        logic [3:0]         r;
    } vec_t;

    exp_t        sb[$];
    exp_t        e;
    vec_t        vecs[20];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned en_cyc = 0;
    int unsigned n_done = 0;
    int unsigned last_done_cyc = 0;
    int unsigned prev_done_cyc = 0;

    always @(posedge ap_clk) begin
        cyc++;
        if (!ap_rst && bus.ce) en_cyc++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic void model(input int a, input int b, output logic [12:0] q, output logic [3:0] r);
        int qi;
        int ri;
        if (b == 0) begin
            qi = -1;
            ri = 0;
        end else begin
            qi = a / b;
            ri = a % b;
        end
        q = qi[12:0];
        r = ri[3:0];
    endfunction

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the first CALC cycle.
    task automatic do_div(input logic [12:0] a, input logic [3:0] b,
                          input logic [12:0] q, input logic [3:0] r,
                          output int unsigned c0);
        int unsigned n;
        n = 0;
        while (!bus.ready && n < 100) begin
            step();
            n++;
        end
        chk("ready_wait", {31'd0, bus.ready}, 32'd1);
        c0 = cyc;
        bus.din0  = a;
        bus.din1  = b;
        bus.start = 1'b1;
        sb.push_back('{q, r, en_cyc});
        step();
        bus.start = 1'b0;
    endtask

    // Result consumer: a done cycle with ce=1 retires one queued result.
    always @(negedge ap_clk) begin
        if (!ap_rst && bus.done && bus.ce) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got dout=%0h exp no done", bus.dout);
            end else begin
                e = sb.pop_front();
                chk("dout", {19'd0, bus.dout}, {19'd0, e.q});
                chk("latency", en_cyc - e.t_acc, 32'd14);
`ifdef SDIV_REM_OUT_EN
                chk("rem", {28'd0, bus.rem}, {28'd0, e.r});
`endif
            end
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            n_done++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int unsigned nd;
        int unsigned n;
        logic [12:0] q;
        logic [3:0]  r;

        vecs[0]  = '{13'sd100,   4'sd7,  13'h000E, 4'h2};
        vecs[1]  = '{-13'sd100,  4'sd7,  13'h1FF2, 4'hE};
        vecs[2]  = '{13'sd100,  -4'sd8,  13'h1FF4, 4'h4};
        vecs[3]  = '{-13'sd4096, -4'sd1, 13'h1000, 4'h0};
        vecs[4]  = '{13'sd55,    4'sd0,  13'h1FFF, 4'h0};
        vecs[5]  = '{-13'sd55,   4'sd0,  13'h1FFF, 4'h0};
        vecs[6]  = '{13'sd4095,  4'sd1,  13'h0FFF, 4'h0};
        vecs[7]  = '{-13'sd4096, 4'sd7,  13'h1DB7, 4'hF};
        vecs[8]  = '{-13'sd4096, -4'sd8, 13'h0200, 4'h0};
        vecs[9]  = '{13'sd7,    -4'sd7,  13'h1FFF, 4'h0};
        vecs[10] = '{13'sd3,     4'sd5,  13'h0000, 4'h3};
        vecs[11] = '{-13'sd1,    4'sd2,  13'h0000, 4'hF};
        for (int i = 12; i < 20; i++) begin
            vecs[i].a = 13'($urandom_range(0, 8191));
            vecs[i].b = 4'($urandom_range(0, 15));
            model(int'(vecs[i].a), int'(vecs[i].b), vecs[i].q, vecs[i].r);
        end

        // Reset state
        ap_rst    = 1'b1;
        bus.ce    = 1'b1;
        bus.start = 1'b0;
        bus.din0  = '0;
        bus.din1  = '0;
        step();
        step();
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("rst_done",  {31'd0, bus.done},  32'd0);
        chk("rst_dout",  {19'd0, bus.dout},  32'd0);
        ap_rst = 1'b0;
        step();
        chk("ready_after_rst", {31'd0, bus.ready}, 32'd1);

        // Table vectors, issued back to back
        for (int i = 0; i < 20; i++) begin
            do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, c0);
        end
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("table_drain", sb.size(), 32'd0);
        chk("throughput", last_done_cyc - prev_done_cyc, 32'd15);

        // Start held high while busy, including the FIX cycle
        nd = n_done;
        do_div(13'sd1234, -4'sd5, 13'h1F0A, 4'h4, c0);
        bus.start = 1'b1;
        bus.din0  = 13'sd999;
        bus.din1  = 4'sd3;
        for (int k = 0; k < 14; k++) begin
            if (cyc == c0 + 14) begin
                chk("fix_done",  {31'd0, bus.done},  32'd1);
                chk("fix_ready", {31'd0, bus.ready}, 32'd0);
            end
            step();
        end
        bus.start = 1'b0;
        repeat (20) step();
        chk("busy_single_done", n_done - nd, 32'd1);
        chk("busy_dout_hold", {19'd0, bus.dout}, 32'h1F0A);

        // ce low 5 cycles mid-CALC, then again while done is pending
        do_div(13'sd1000, 4'sd3, 13'h014D, 4'h1, c0);
        repeat (3) step();
        bus.ce = 1'b0;
        repeat (5) step();
        bus.ce = 1'b1;
        n = 0;
        while (!bus.done && n < 40) begin
            step();
            n++;
        end
        bus.ce = 1'b0;
        chk("stall_done_cycle", cyc - c0, 32'd19);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_done_held", {31'd0, bus.done}, 32'd1);
            chk("stall_dout", {19'd0, bus.dout}, 32'h014D);
        end
        bus.ce = 1'b1;
        step();
        chk("done_pulse_end", {31'd0, bus.done}, 32'd0);

        // Reset in the middle of a division
        nd = n_done;
        do_div(13'sd500, 4'sd3, 13'h00A6, 4'h2, c0);
        repeat (5) step();
        ap_rst = 1'b1;
        sb.delete();
        step();
        chk("midrst_ready", {31'd0, bus.ready}, 32'd0);
        chk("midrst_dout",  {19'd0, bus.dout},  32'd0);
        chk("midrst_done",  {31'd0, bus.done},  32'd0);
        ap_rst = 1'b0;
        step();
        chk("midrst_ready_after", {31'd0, bus.ready}, 32'd1);
        repeat (20) step();
        chk("midrst_no_done", n_done - nd, 32'd0);
        do_div(-13'sd777, 4'sd6, 13'h1F7F, 4'hD, c0);
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk("final_drain", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
